// File: rtl/move_sequencer.sv
// rtl/move_sequencer.sv - debounced push-button to position-counter step sequencer

// Two-flop synchroniser plus stability counter for one raw button.
module move_debounce #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // Synchronise, then accept a new level only after it has differed for DEBOUNCE_CYC cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// Top: resolves button requests into single-cycle clamped steps with hold-to-repeat.
module move_sequencer #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int HOLD_DELAY   = 8,
  parameter int REPEAT_PER   = 4,
  parameter int POS_MIN      = 0,
  parameter int POS_MAX      = 639
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       pbR,
  input  logic       pbL,
  input  logic [9:0] playerpos,
  output logic [1:0] ctrl
);

  // Request encoding deliberately matches the ctrl step encoding.
  typedef enum logic [1:0] {
    REQ_NONE  = 2'b00,
    REQ_RIGHT = 2'b01,
    REQ_LEFT  = 2'b10
  } req_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DELAY  = 2'b01,
    REPEAT = 2'b10
  } state_t;

  localparam int TMR_MAX = (HOLD_DELAY > REPEAT_PER) ? HOLD_DELAY : REPEAT_PER;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] HOLD_LOAD   = TMR_W'(HOLD_DELAY - 1);
  localparam logic [TMR_W-1:0] REPEAT_LOAD = TMR_W'(REPEAT_PER - 1);
  localparam logic [9:0]       POS_MIN_C   = 10'(POS_MIN);
  localparam logic [9:0]       POS_MAX_C   = 10'(POS_MAX);

  logic             lvl_r;
  logic             lvl_l;
  req_t             req;
  logic [1:0]       step_cmd;
  state_t           state;
  req_t             dir;
  logic [TMR_W-1:0] tmr;

  move_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_r (
    .clk   (clk),
    .reset (reset),
    .raw   (pbR),
    .level (lvl_r)
  );

  move_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_l (
    .clk   (clk),
    .reset (reset),
    .raw   (pbL),
    .level (lvl_l)
  );

  // Decode debounced levels; simultaneous presses cancel out.
  always_comb begin
    req = REQ_NONE;
    case ({lvl_r, lvl_l})
      2'b10:   req = REQ_RIGHT;
      2'b01:   req = REQ_LEFT;
      default: req = REQ_NONE;
    endcase
  end

  // Step value a due step would drive, blanked at the playfield limits.
  always_comb begin
    step_cmd = 2'b00;
    if (req == REQ_RIGHT && playerpos < POS_MAX_C) begin
      step_cmd = 2'b01;
    end else if (req == REQ_LEFT && playerpos > POS_MIN_C) begin
      step_cmd = 2'b10;
    end
  end

  // Hold-to-repeat FSM; ctrl is a registered one-cycle pulse, timers advance even when clamped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      dir   <= REQ_RIGHT;
      tmr   <= '0;
      ctrl  <= 2'b00;
    end else begin
      ctrl <= 2'b00;
      if (!enable) begin
        state <= IDLE;
        tmr   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (req != REQ_NONE) begin
              dir   <= req;
              ctrl  <= step_cmd;
              tmr   <= HOLD_LOAD;
              state <= DELAY;
            end
          end
          DELAY, REPEAT: begin
            if (req != dir) begin
              state <= IDLE;
              tmr   <= '0;
            end else if (tmr == '0) begin
              ctrl  <= step_cmd;
              tmr   <= REPEAT_LOAD;
              state <= REPEAT;
            end else begin
              tmr <= tmr - TMR_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            tmr   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// tb/tb_move_sequencer.sv - directed self-checking bench for move_sequencer

module tb_move_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       pbR;
  logic       pbL;
  logic [9:0] playerpos;
  logic [1:0] ctrl;

  int pass_cnt  = 0;
  int total_cnt = 0;

  move_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .pbR       (pbR),
    .pbL       (pbL),
    .playerpos (playerpos),
    .ctrl      (ctrl)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    enable    = 1'b1;
    pbR       = 1'b0;
    pbL       = 1'b0;
    playerpos = 10'd100;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (ctrl !== 2'b00) $display("FAIL reset_ctrl cycle %0d: got %b want 00", i, ctrl);
      else pass_cnt++;
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_hold_right();
    logic [1:0] exp;
    playerpos = 10'd100;
    pbR = 1'b1;
    for (int e = 0; e <= 33; e++) begin
      if (e == 26) pbR = 1'b0;
      tick();
      exp = (e == 6 || e == 14 || e == 18 || e == 22 || e == 26 || e == 30) ? 2'b01 : 2'b00;
      total_cnt++;
      if (ctrl !== exp) $display("FAIL hold_right edge %0d: got %b want %b", e, ctrl, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_glitch();
    pbL = 1'b1;
    for (int e = 0; e <= 14; e++) begin
      if (e == 3) pbL = 1'b0;
      tick();
      total_cnt++;
      if (ctrl !== 2'b00) $display("FAIL glitch edge %0d: got %b want 00", e, ctrl);
      else pass_cnt++;
    end
  endtask

  task automatic test_both();
    logic [1:0] exp;
    pbR = 1'b1;
    pbL = 1'b1;
    for (int e = 0; e <= 11; e++) begin
      tick();
      total_cnt++;
      if (ctrl !== 2'b00) $display("FAIL both_held edge %0d: got %b want 00", e, ctrl);
      else pass_cnt++;
    end
    for (int e = 0; e <= 23; e++) begin
      if (e == 0) pbL = 1'b0;
      if (e == 16) pbR = 1'b0;
      tick();
      exp = (e == 6 || e == 14 || e == 18) ? 2'b01 : 2'b00;
      total_cnt++;
      if (ctrl !== exp) $display("FAIL both_release_l edge %0d: got %b want %b", e, ctrl, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_limit_min();
    logic [1:0] exp;
    playerpos = 10'd0;
    pbL = 1'b1;
    for (int e = 0; e <= 33; e++) begin
      if (e == 21) playerpos = 10'd1;
      if (e == 27) pbL = 1'b0;
      tick();
      exp = (e == 22 || e == 26 || e == 30) ? 2'b10 : 2'b00;
      total_cnt++;
      if (ctrl !== exp) $display("FAIL limit_min edge %0d: got %b want %b", e, ctrl, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_limit_max();
    logic [1:0] exp;
    playerpos = 10'd639;
    pbR = 1'b1;
    for (int e = 0; e <= 23; e++) begin
      if (e == 11) playerpos = 10'd638;
      if (e == 16) pbR = 1'b0;
      tick();
      exp = (e == 14 || e == 18) ? 2'b01 : 2'b00;
      total_cnt++;
      if (ctrl !== exp) $display("FAIL limit_max edge %0d: got %b want %b", e, ctrl, exp);
      else pass_cnt++;
    end
    playerpos = 10'd100;
  endtask

  task automatic test_enable();
    logic [1:0] exp;
    playerpos = 10'd100;
    pbR = 1'b1;
    for (int e = 0; e <= 42; e++) begin
      if (e == 20) enable = 1'b0;
      if (e == 21) enable = 1'b1;
      if (e == 35) pbR = 1'b0;
      tick();
      exp = (e == 6 || e == 14 || e == 18 || e == 21 || e == 29 || e == 33 || e == 37) ? 2'b01 : 2'b00;
      total_cnt++;
      if (ctrl !== exp) $display("FAIL enable edge %0d: got %b want %b", e, ctrl, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    logic [1:0] exp;
    playerpos = 10'd100;
    pbR = 1'b1;
    for (int e = 0; e <= 18; e++) begin
      tick();
      exp = (e == 6 || e == 14 || e == 18) ? 2'b01 : 2'b00;
      total_cnt++;
      if (ctrl !== exp) $display("FAIL pre_reset edge %0d: got %b want %b", e, ctrl, exp);
      else pass_cnt++;
    end
    #2;
    reset = 1'b0;
    #1;
    total_cnt++;
    if (ctrl !== 2'b00) $display("FAIL async_reset_immediate: got %b want 00", ctrl);
    else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if (ctrl !== 2'b00) $display("FAIL async_reset_held: got %b want 00", ctrl);
    else pass_cnt++;
    reset = 1'b1;
    for (int e = 0; e <= 22; e++) begin
      if (e == 15) pbR = 1'b0;
      tick();
      exp = (e == 6 || e == 14 || e == 18) ? 2'b01 : 2'b00;
      total_cnt++;
      if (ctrl !== exp) $display("FAIL post_reset edge %0d: got %b want %b", e, ctrl, exp);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_hold_right();
    test_glitch();
    test_both();
    test_limit_min();
    test_limit_max();
    test_enable();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
